// File: rtl/gbf_ram_pkg.sv
// Shared types and helpers for the GBF banked single-port RAM arbiter.
package gbf_ram_pkg;

  localparam int unsigned GBF_MAX_DEFER_W = 4;

  // Kind of bank access performed in a given cycle
  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_WR,
    ACC_RD_PEND,
    ACC_RD_NEW
  } acc_e;

  // Bank index of a logical address (upper bits above the per-bank address)
  function automatic int unsigned bank_of(input logic [31:0] addr,
                                          input int unsigned bank_depth_bit);
    return addr >> bank_depth_bit;
  endfunction

endpackage

// File: rtl/gbf_sp_bank.sv
// Behavioural single-port bank: active-low chip-select / write-enable,
// registered read data. Stands in for the hard SRAM macro.
module gbf_sp_bank #(
  parameter int unsigned WIDTH    = 28,
  parameter int unsigned ADDR_BIT = 6
) (
  input  logic                clk,
  input  logic                csb,
  input  logic                web,
  input  logic [ADDR_BIT-1:0] addr,
  input  logic [WIDTH-1:0]    din,
  output logic [WIDTH-1:0]    dout
);

  logic [WIDTH-1:0] mem [2**ADDR_BIT];

  // Single port: write when selected with web low, otherwise read into dout
  always_ff @(posedge clk) begin
    if (!csb) begin
      if (!web) mem[addr] <= din;
      else      dout      <= mem[addr];
    end
  end

endmodule

// File: rtl/gbf_sp_ram_arb.sv
// Banked single-port GBF buffer with write/read arbitration, a one-entry
// deferred-read buffer, starvation guard and read-valid signalling.
module gbf_sp_ram_arb
  import gbf_ram_pkg::*;
#(
  parameter int unsigned WIDTH          = 28,
  parameter int unsigned DEPTH_BIT      = 8,
  parameter int unsigned BANK_DEPTH_BIT = 6,
  parameter int unsigned OUT_REG        = 0,
  parameter int unsigned MAX_DEFER      = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  output logic                 wr_ready,
  input  logic [DEPTH_BIT-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_req,
  output logic                 rd_ready,
  input  logic [DEPTH_BIT-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 rd_valid
);

  localparam int unsigned NUM_BANKS = 1 << (DEPTH_BIT - BANK_DEPTH_BIT);
  localparam int unsigned BANK_W    = (DEPTH_BIT > BANK_DEPTH_BIT) ?
                                      (DEPTH_BIT - BANK_DEPTH_BIT) : 1;

  logic                       pend_valid, pend_valid_n;
  logic [DEPTH_BIT-1:0]       pend_addr, pend_addr_n;
  logic [GBF_MAX_DEFER_W-1:0] defer_cnt, defer_cnt_n;

  acc_e                       acc;
  logic [DEPTH_BIT-1:0]       acc_addr;
  logic [BANK_W-1:0]          sel_bank;
  logic                       defer_full, wr_acc, rd_acc, acc_rd;

  logic [NUM_BANKS-1:0]       bank_csb, bank_web;
  logic [WIDTH-1:0]           bank_do [NUM_BANKS];

  logic                       v1;
  logic [BANK_W-1:0]          bank1;
  logic [WIDTH-1:0]           data_mux, rd_q;

  assign defer_full = pend_valid && (defer_cnt == GBF_MAX_DEFER_W'(MAX_DEFER));
  assign wr_ready   = ~defer_full;
  assign rd_ready   = ~pend_valid;
  assign wr_acc     = wr_en & wr_ready;
  assign rd_acc     = rd_req & rd_ready;

  // Arbitration: starved pending read, then write, then pending read, then new read
  always_comb begin
    acc          = ACC_IDLE;
    acc_addr     = rd_addr;
    pend_valid_n = pend_valid;
    pend_addr_n  = pend_addr;
    defer_cnt_n  = defer_cnt;
    if (defer_full) begin
      acc          = ACC_RD_PEND;
      acc_addr     = pend_addr;
      pend_valid_n = 1'b0;
      defer_cnt_n  = '0;
    end else if (wr_acc) begin
      acc      = ACC_WR;
      acc_addr = wr_addr;
      if (pend_valid) begin
        defer_cnt_n = defer_cnt + 1'b1;
      end else if (rd_acc) begin
        pend_valid_n = 1'b1;
        pend_addr_n  = rd_addr;
        defer_cnt_n  = GBF_MAX_DEFER_W'(1);
      end
    end else if (pend_valid) begin
      acc          = ACC_RD_PEND;
      acc_addr     = pend_addr;
      pend_valid_n = 1'b0;
      defer_cnt_n  = '0;
    end else if (rd_acc) begin
      acc      = ACC_RD_NEW;
      acc_addr = rd_addr;
    end
  end

  // Deferred-read buffer and defer counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      defer_cnt  <= '0;
    end else begin
      pend_valid <= pend_valid_n;
      pend_addr  <= pend_addr_n;
      defer_cnt  <= defer_cnt_n;
    end
  end

  assign acc_rd   = (acc == ACC_RD_PEND) || (acc == ACC_RD_NEW);
  assign sel_bank = BANK_W'(bank_of(32'(acc_addr), BANK_DEPTH_BIT));

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign bank_csb[b] = !((acc != ACC_IDLE) && (sel_bank == BANK_W'(b)));
    assign bank_web[b] = bank_csb[b] | (acc != ACC_WR);

    gbf_sp_bank #(
      .WIDTH    (WIDTH),
      .ADDR_BIT (BANK_DEPTH_BIT)
    ) u_bank (
      .clk  (clk),
      .csb  (bank_csb[b]),
      .web  (bank_web[b]),
      .addr (acc_addr[BANK_DEPTH_BIT-1:0]),
      .din  (wr_data),
      .dout (bank_do[b])
    );
  end

  assign data_mux = bank_do[bank1];

  // First read stage: valid flag and bank index matching the bank's registered DO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      bank1 <= '0;
    end else begin
      v1 <= acc_rd;
      if (acc_rd) bank1 <= sel_bank;
    end
  end

  // Captured read word: hold value for OUT_REG=0, output register for OUT_REG=1
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rd_q <= '0;
    else if (v1) rd_q <= data_mux;
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic v2;

    // Second read stage valid flag
    always_ff @(posedge clk or posedge rst) begin
      if (rst) v2 <= 1'b0;
      else     v2 <= v1;
    end

    assign rd_valid = v2;
    assign rd_data  = rd_q;
  end else begin : g_out_comb
    assign rd_valid = v1;
    assign rd_data  = v1 ? data_mux : rd_q;
  end

endmodule

// File: tb/tb_gbf_sp_ram_arb.sv
// Scoreboard bench for gbf_sp_ram_arb: two instances (OUT_REG=0 and 1) share
// stimulus; a reference model predicts handshakes, bank activity and read data.
module tb_gbf_sp_ram_arb;

  localparam int WIDTH          = 28;
  localparam int DEPTH_BIT      = 8;
  localparam int BANK_DEPTH_BIT = 6;
  localparam int MAX_DEFER      = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 wr_en = 1'b0, rd_req = 1'b0;
  logic [DEPTH_BIT-1:0] wr_addr = '0, rd_addr = '0;
  logic [WIDTH-1:0]     wr_data = '0;
  logic                 wr_ready0, rd_ready0, rd_valid0;
  logic                 wr_ready1, rd_ready1, rd_valid1;
  logic [WIDTH-1:0]     rd_data0, rd_data1;

  gbf_sp_ram_arb #(.WIDTH(WIDTH), .DEPTH_BIT(DEPTH_BIT), .BANK_DEPTH_BIT(BANK_DEPTH_BIT),
                   .OUT_REG(0), .MAX_DEFER(MAX_DEFER)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ready(wr_ready0), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_req(rd_req), .rd_ready(rd_ready0), .rd_addr(rd_addr),
    .rd_data(rd_data0), .rd_valid(rd_valid0));

  gbf_sp_ram_arb #(.WIDTH(WIDTH), .DEPTH_BIT(DEPTH_BIT), .BANK_DEPTH_BIT(BANK_DEPTH_BIT),
                   .OUT_REG(1), .MAX_DEFER(MAX_DEFER)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ready(wr_ready1), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_req(rd_req), .rd_ready(rd_ready1), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               cyc;
  } exp_t;

  exp_t             q0[$], q1[$];
  logic [WIDTH-1:0] mem [256];
  bit               m_pend;
  logic [7:0]       m_paddr;
  int               m_cnt;
  logic [WIDTH-1:0] last0 = '0, last1 = '0;
  int               n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Read reaches the bank at the coming edge; data appears 1 or 2 cycles after
  task automatic issue_read(input logic [7:0] a);
    q0.push_back('{mem[a], cyc + 1});
    q1.push_back('{mem[a], cyc + 2});
  endtask

  task automatic step(input bit we, input logic [7:0] wa, input logic [WIDTH-1:0] wd,
                      input bit rq, input logic [7:0] ra);
    bit exp_wr, exp_rd, wacc, racc;
    int nacc;
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd; rd_req = rq; rd_addr = ra;
    #1;
    exp_wr = !(m_pend && m_cnt == MAX_DEFER);
    exp_rd = !m_pend;
    chk("wr_ready0", wr_ready0, exp_wr);
    chk("wr_ready1", wr_ready1, exp_wr);
    chk("rd_ready0", rd_ready0, exp_rd);
    chk("rd_ready1", rd_ready1, exp_rd);
    wacc = we && exp_wr;
    racc = rq && exp_rd;
    nacc = 1;
    if (m_pend && m_cnt == MAX_DEFER) begin
      issue_read(m_paddr); m_pend = 0; m_cnt = 0;
    end else if (wacc) begin
      mem[wa] = wd;
      if (m_pend) m_cnt++;
      else if (racc) begin m_pend = 1; m_paddr = ra; m_cnt = 1; end
    end else if (m_pend) begin
      issue_read(m_paddr); m_pend = 0; m_cnt = 0;
    end else if (racc) begin
      issue_read(ra);
    end else begin
      nacc = 0;
    end
    chk("bank_cs0", $countones(~dut0.bank_csb), nacc);
    chk("bank_cs1", $countones(~dut1.bank_csb), nacc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, '0, 0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b0; rd_req = 1'b0;
    m_pend = 0; m_cnt = 0;
    q0.delete(); q1.delete();
    last0 = '0; last1 = '0;
    @(negedge clk);
    chk("rst_wr_ready", wr_ready0 & wr_ready1, 1);
    chk("rst_rd_ready", rd_ready0 & rd_ready1, 1);
    chk("rst_rd_valid", rd_valid0 | rd_valid1, 0);
    chk("rst_rd_data0", rd_data0, 0);
    chk("rst_rd_data1", rd_data1, 0);
    rst = 1'b0;
  endtask

  // Monitor for the OUT_REG=0 instance
  initial forever begin
    exp_t e;
    @(posedge clk); #1;
    if (rd_valid0) begin
      if (q0.size() == 0) begin
        n_chk++;
        $display("FAIL spurious_valid0: got rd_valid=1 expected no read outstanding (cycle %0d)", cyc);
      end else begin
        e = q0.pop_front();
        chk("rd_data0", rd_data0, e.data);
        chk("latency0", cyc, e.cyc);
      end
      last0 = rd_data0;
    end else begin
      chk("hold0", rd_data0, last0);
    end
  end

  // Monitor for the OUT_REG=1 instance
  initial forever begin
    exp_t e;
    @(posedge clk); #1;
    if (rd_valid1) begin
      if (q1.size() == 0) begin
        n_chk++;
        $display("FAIL spurious_valid1: got rd_valid=1 expected no read outstanding (cycle %0d)", cyc);
      end else begin
        e = q1.pop_front();
        chk("rd_data1", rd_data1, e.data);
        chk("latency1", cyc, e.cyc);
      end
      last1 = rd_data1;
    end else begin
      chk("hold1", rd_data1, last1);
    end
  end

  initial begin
    logic [7:0] wa, ra;
    m_pend = 0; m_cnt = 0;
    repeat (2) @(negedge clk);
    chk("reset_wr_ready", wr_ready0 & wr_ready1, 1);
    chk("reset_rd_ready", rd_ready0 & rd_ready1, 1);
    chk("reset_rd_valid", rd_valid0 | rd_valid1, 0);
    chk("reset_rd_data0", rd_data0, 0);
    chk("reset_rd_data1", rd_data1, 0);
    rst = 1'b0;

    // Give every location a known value
    for (int a = 0; a < 256; a++) step(1, 8'(a), WIDTH'($urandom), 0, 8'h00);

    // Write then read
    step(1, 8'h05, 28'h0ABCDEF, 0, 8'h00);
    step(0, 8'h00, '0, 1, 8'h05);
    idle(3);

    // Same-address collision: write wins, deferred read sees new data
    step(1, 8'h41, 28'h1234567, 1, 8'h41);
    idle(4);

    // Starvation guard: writes every cycle behind one collided read
    step(1, 8'h10, 28'h0000111, 1, 8'h20);
    for (int i = 0; i < 5; i++) step(1, 8'(8'h11 + i), WIDTH'($urandom), 0, 8'h00);
    idle(3);

    // Bank crossing, back-to-back reads
    step(1, 8'h3F, 28'h000000A, 0, 8'h00);
    step(1, 8'h40, 28'h000000B, 0, 8'h00);
    step(1, 8'hFF, 28'h000000C, 0, 8'h00);
    step(0, 8'h00, '0, 1, 8'h3F);
    step(0, 8'h00, '0, 1, 8'h40);
    step(0, 8'h00, '0, 1, 8'hFF);
    idle(3);

    // Reset with a pending read; data written earlier stays readable
    step(1, 8'h41, 28'h7654321, 1, 8'h41);
    do_reset();
    step(0, 8'h00, '0, 1, 8'h05);
    step(0, 8'h00, '0, 1, 8'h41);
    idle(3);

    // Idle hold after a read
    step(0, 8'h00, '0, 1, 8'h40);
    idle(10);

    // Randomised traffic, biased toward address collisions
    for (int i = 0; i < 3000; i++) begin
      wa = 8'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? wa : 8'($urandom);
      step($urandom_range(0, 1) == 1, wa, WIDTH'($urandom), $urandom_range(0, 1) == 1, ra);
    end
    idle(6);

    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gbf_sp_ram_arb.md
Name: gbf_sp_ram_arb

Overview:
- Parametrised successor to the per-buffer single-port SRAM wrappers.
- Builds one logical WIDTH x 2^DEPTH_BIT buffer from NUM_BANKS single-port banks. Upper address bits select the bank.
- Arbitrates the single physical port between a write channel and a read channel, instead of silently dropping a read that collides with a write.
- Adds a one-entry deferred-read buffer, a starvation guard, read-valid signalling and an optional output register. Sits between GBF fill/drain controllers and the SRAM macros.

Parameters:
- WIDTH, 28, data word width.
- DEPTH_BIT, 8, logical address width.
- BANK_DEPTH_BIT, 6, per-bank address width; NUM_BANKS = 2^(DEPTH_BIT-BANK_DEPTH_BIT); requires DEPTH_BIT >= BANK_DEPTH_BIT.
- OUT_REG, 0, 1 adds an output register stage (read latency +1).
- MAX_DEFER, 3, maximum consecutive cycles a pending read may lose to writes; range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- wr_ready  out  1  write accepted this cycle when wr_en & wr_ready.
- wr_addr  in  DEPTH_BIT  write address.
- wr_data  in  WIDTH  write data.
- rd_req  in  1  read request.
- rd_ready  out  1  read accepted this cycle when rd_req & rd_ready.
- rd_addr  in  DEPTH_BIT  read address.
- rd_data  out  WIDTH  read data.
- rd_valid  out  1  one-cycle pulse qualifying rd_data.

Behaviour:
- Reset values: wr_ready=1, rd_ready=1, rd_valid=0, rd_data=0, pending buffer empty, defer counter=0. Memory contents are not reset.
- Reset mid-operation: a pending read and any in-flight rd_valid are discarded. No rd_valid is produced for requests accepted before reset.
- Port access: at most one bank access per cycle, either one read or one write.
- Bank select and chip-select:
  - bank = addr[DEPTH_BIT-1:BANK_DEPTH_BIT].
  - Only the selected bank sees chip-select; its write-enable is active for writes.
  - All other banks are idle.
- rd_ready = ~pending_valid. rd_ready is combinational from state only, not from rd_req.
- wr_ready = ~(pending_valid & defer_cnt == MAX_DEFER).
- Arbitration priority each cycle:
  1. Pending read with defer_cnt == MAX_DEFER: read issues; wr_ready=0, so the write is stalled.
  2. Accepted write (wr_en & wr_ready): write issues. If a pending read exists, defer_cnt increments. If rd_req & rd_ready in the same cycle, the read is captured into the pending buffer with defer_cnt=1.
  3. Pending read: issues; buffer clears; defer_cnt=0.
  4. New accepted read: issues directly.
- Read semantics:
  - A read returns the array contents at the cycle it accesses the bank.
  - A read deferred behind a write to the same address returns the new data (write-first).
- Latency, counted from the cycle the read accesses the bank:
  - rd_valid asserts 1 cycle later when OUT_REG=0, 2 cycles later when OUT_REG=1.
  - A bank-index register per pipeline stage drives the output mux.
- rd_data holds its last value when rd_valid=0. Issued reads are back-to-back capable, with throughput 1/cycle.
- Idle cycle (no wr_en, no rd_req, no pending read): no bank selected; power hold.
- Address wrap: addresses are used modulo 2^DEPTH_BIT; there is no out-of-range condition.

Decomposition:
- Package gbf_ram_pkg:
  - GBF_MAX_DEFER_W = 4.
  - Function bank_of(addr).
  - Access-type enum {ACC_IDLE, ACC_WR, ACC_RD_PEND, ACC_RD_NEW}.
- Sub-module gbf_sp_bank:
  - Behavioural single-port bank (CSB/WEB active-low, registered DO), 2^BANK_DEPTH_BIT x WIDTH.
  - Instantiated NUM_BANKS times via generate; replaceable by the hard macro in synthesis.

Test Plan:
- Write-then-read, OUT_REG=0: write 0x0ABCDEF to addr 5; read addr 5 next cycle -> rd_valid=1 with rd_data=0x0ABCDEF exactly 1 cycle after the read cycle. With OUT_REG=1 -> same data, 2 cycles after.
- Collision write-first: wr_en addr 0x41 data 0x1234567 and rd_req addr 0x41 in the same cycle -> write issues; read pends; rd_ready=0 the next cycle; rd_valid carries 0x1234567 one cycle after the deferred read issues.
- Starvation guard, MAX_DEFER=3: hold wr_en every cycle with one collided read -> defer_cnt reaches 3, wr_ready=0 for exactly 1 cycle, the read issues, then wr_ready returns to 1.
- Bank crossing, DEPTH_BIT=8, BANK_DEPTH_BIT=6: write 0xA at 0x3F, 0xB at 0x40, 0xC at 0xFF; back-to-back reads -> rd_data 0xA, 0xB, 0xC on consecutive rd_valid cycles; only one bank chip-select active per cycle.
- Reset mid-operation: create a pending read, assert rst for 1 cycle -> rd_ready=1, wr_ready=1, no rd_valid afterwards; previously written data is still readable.
- Idle/hold: after a read, 10 idle cycles -> rd_valid=0 throughout, rd_data unchanged, no bank selected.
